// File: rtl/sim_test_pkg.sv
// Shared types and register offsets for the simulation test-status controller.
package sim_test_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam int STATUS_OFS  = 'h00;
    localparam int END_OFS     = 'h04;
    localparam int CYCLE_OFS   = 'h08;
    localparam int CH_BASE_OFS = 'h10;

    function automatic logic [31:0] status_word(state_t s);
        return {27'b0, (s == ST_TIMEOUT), (s == ST_PASS), (s != ST_RUN), s};
    endfunction

endpackage

// File: rtl/sim_test_channel.sv
// One report channel: saturating fail counter plus the last non-zero failure code.
module sim_test_channel #(
    parameter int FAIL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_wr,
    input  logic [31:0]       i_wdata,
    output logic [FAIL_W-1:0] o_fail_cnt,
    output logic [31:0]       o_rd_word
);

    localparam logic [FAIL_W-1:0] FAIL_MAX = '1;

    logic [FAIL_W-1:0] r_fail_cnt;
    logic [7:0]        r_last_code;
    logic [15:0]       w_cnt16;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fail_cnt  <= '0;
            r_last_code <= '0;
        end else if (i_enable && i_wr && (i_wdata != 32'd0)) begin
            if (r_fail_cnt != FAIL_MAX) begin
                r_fail_cnt <= r_fail_cnt + 1'b1;
            end
            r_last_code <= i_wdata[7:0];
        end
    end

    // Count field in the read word is 16 bits wide regardless of FAIL_W.
    generate
        if (FAIL_W >= 16) begin : g_cnt_trunc
            assign w_cnt16 = r_fail_cnt[15:0];
        end else begin : g_cnt_ext
            assign w_cnt16 = {{(16-FAIL_W){1'b0}}, r_fail_cnt};
        end
    endgenerate

    assign o_fail_cnt = r_fail_cnt;
    assign o_rd_word  = {r_last_code, 8'h00, w_cnt16};

endmodule

// File: rtl/sim_test_ctrl.sv
// Memory-mapped test-status controller: run FSM, cycle watchdog, bus decode and read mux.
module sim_test_ctrl
    import sim_test_pkg::*;
#(
    parameter int MAX_CYCLES = 256,
    parameter int CNT_W      = 32,
    parameter int NUM_CH     = 4,
    parameter int FAIL_W     = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_done,
    output logic              o_passed,
    output logic              o_timed_out,
    output logic [FAIL_W-1:0] o_fail_total,
    output logic [CNT_W-1:0]  o_cycle_count
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int SUM_W  = FAIL_W + 4;
    localparam logic [SUM_W-1:0] SUM_MAX = {{4{1'b0}}, {FAIL_W{1'b1}}};

    state_t             r_state;
    logic [CNT_W-1:0]   r_cycle;
    logic               r_done;
    logic               r_passed;
    logic               r_timed_out;
    logic [31:0]        r_rdata;

    logic [WORD_W-1:0]  w_word;
    logic               w_wr;
    logic               w_rd;
    logic               w_run;
    logic               w_end_wr;
    logic               w_wdog;
    logic [FAIL_W-1:0]  w_fail_cnt [NUM_CH];
    logic [31:0]        w_ch_rd    [NUM_CH];
    logic [SUM_W-1:0]   w_sum;
    logic [FAIL_W-1:0]  w_fail_total;
    logic [31:0]        w_cycle32;
    logic [31:0]        w_rd_data;
    logic               w_unused;

    assign w_word   = i_addr[ADDR_W-1:2];
    assign w_unused = ^i_addr[1:0];
    assign w_wr     = i_en && i_we;
    assign w_rd     = i_en && !i_we;
    assign w_run    = (r_state == ST_RUN);
    assign w_end_wr = w_wr && (w_word == WORD_W'(END_OFS / 4));
    assign w_wdog   = (r_cycle == CNT_W'(MAX_CYCLES - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            sim_test_channel #(
                .FAIL_W (FAIL_W)
            ) u_channel (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_enable   (w_run),
                .i_wr       (w_wr && (w_word == WORD_W'(CH_BASE_OFS / 4 + gi))),
                .i_wdata    (i_wdata),
                .o_fail_cnt (w_fail_cnt[gi]),
                .o_rd_word  (w_ch_rd[gi])
            );
        end

        if (CNT_W >= 32) begin : g_cyc_trunc
            assign w_cycle32 = r_cycle[31:0];
        end else begin : g_cyc_ext
            assign w_cycle32 = {{(32-CNT_W){1'b0}}, r_cycle};
        end
    endgenerate

    // Wide accumulator cannot overflow for up to 8 channels; clamp afterwards.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum = w_sum + SUM_W'(w_fail_cnt[i]);
        end
        w_fail_total = (w_sum > SUM_MAX) ? SUM_MAX[FAIL_W-1:0] : w_sum[FAIL_W-1:0];
    end

    always_comb begin
        w_rd_data = 32'd0;
        if (w_word == WORD_W'(STATUS_OFS / 4)) begin
            w_rd_data = status_word(r_state);
        end else if (w_word == WORD_W'(CYCLE_OFS / 4)) begin
            w_rd_data = w_cycle32;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_word == WORD_W'(CH_BASE_OFS / 4 + i)) begin
                    w_rd_data = w_ch_rd[i];
                end
            end
        end
    end

    // END beats the watchdog; the counter freezes on the edge that leaves RUN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RUN;
            r_cycle     <= '0;
            r_done      <= 1'b0;
            r_passed    <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_end_wr) begin
                r_done <= 1'b1;
                if (w_fail_total != '0) begin
                    r_state <= ST_FAIL;
                end else begin
                    r_state  <= ST_PASS;
                    r_passed <= 1'b1;
                end
            end else if (w_wdog) begin
                r_state     <= ST_TIMEOUT;
                r_done      <= 1'b1;
                r_timed_out <= 1'b1;
            end else begin
                r_cycle <= r_cycle + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'd0;
        end else if (w_rd) begin
            r_rdata <= w_rd_data;
        end
    end

    assign o_rdata       = r_rdata;
    assign o_done        = r_done;
    assign o_passed      = r_passed;
    assign o_timed_out   = r_timed_out;
    assign o_fail_total  = w_fail_total;
    assign o_cycle_count = r_cycle;

endmodule

// File: tb/tb_sim_test_ctrl.sv
// Self-checking bench for sim_test_ctrl: directed sequences, a vector table and random traffic.
module tb_sim_test_ctrl;

    localparam int MAXC = 256;
    localparam int NCH  = 4;
    localparam int FMAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] wdata = 32'd0;

    logic [31:0] rdata;
    logic        done, passed, timed_out;
    logic [15:0] fail_total;
    logic [31:0] cycle_count;

    logic [31:0] s_rdata;
    logic        s_done, s_passed, s_timed_out;
    logic [1:0]  s_fail_total;
    logic [31:0] s_cycle_count;

    sim_test_ctrl #(
        .MAX_CYCLES (MAXC), .CNT_W (32), .NUM_CH (NCH), .FAIL_W (16), .ADDR_W (8)
    ) u_dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_en (en), .i_we (we), .i_addr (addr),
        .i_wdata (wdata), .o_rdata (rdata), .o_done (done), .o_passed (passed),
        .o_timed_out (timed_out), .o_fail_total (fail_total), .o_cycle_count (cycle_count)
    );

    sim_test_ctrl #(
        .MAX_CYCLES (MAXC), .CNT_W (32), .NUM_CH (2), .FAIL_W (2), .ADDR_W (8)
    ) u_dut_sat (
        .i_clk (clk), .i_rst_n (rst_n), .i_en (en), .i_we (we), .i_addr (addr),
        .i_wdata (wdata), .o_rdata (s_rdata), .o_done (s_done), .o_passed (s_passed),
        .o_timed_out (s_timed_out), .o_fail_total (s_fail_total), .o_cycle_count (s_cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: verdict code 0=RUN 1=PASS 2=FAIL 3=TIMEOUT
    int          m_state;
    int unsigned m_cycle;
    int unsigned m_fail [NCH];
    logic [7:0]  m_code [NCH];
    logic [31:0] m_rdata;

    function automatic int unsigned m_total();
        int unsigned s = 0;
        for (int i = 0; i < NCH; i++) s += m_fail[i];
        return (s > FMAX) ? FMAX : s;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int wd = int'(a[7:2]);
        int st = m_state;
        if (wd == 0)
            return 32'((st == 3) * 16 + (st == 1) * 8 + (st != 0) * 4 + st);
        if (wd == 2) return m_cycle;
        if (wd >= 4 && wd < 4 + NCH) return {m_code[wd-4], 8'h00, 16'(m_fail[wd-4])};
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cycle = 0; m_rdata = 0;
        for (int i = 0; i < NCH; i++) begin m_fail[i] = 0; m_code[i] = 0; end
    endtask

    task automatic model_step(input logic e, input logic w, input logic [7:0] a, input logic [31:0] d);
        int wd = int'(a[7:2]);
        logic [31:0] rv = m_read(a);
        if (e && !w) m_rdata = rv;
        if (m_state != 0) return;
        if (e && w && wd == 1) begin
            m_state = (m_total() != 0) ? 2 : 1;
            return;
        end
        if (e && w && wd >= 4 && wd < 4 + NCH && d != 0) begin
            if (m_fail[wd-4] < FMAX) m_fail[wd-4]++;
            m_code[wd-4] = d[7:0];
        end
        if (m_cycle == MAXC - 1) m_state = 3;
        else m_cycle++;
    endtask

    task automatic step(input logic e, input logic w, input logic [7:0] a, input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        model_step(e, w, a, d);
        en = 1'b0; we = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, " rdata"},       rdata,       m_rdata);
        check({tag, " done"},        done,        (m_state != 0));
        check({tag, " passed"},      passed,      (m_state == 1));
        check({tag, " timed_out"},   timed_out,   (m_state == 3));
        check({tag, " fail_total"},  fail_total,  m_total());
        check({tag, " cycle_count"}, cycle_count, m_cycle);
    endtask

    task automatic do_reset();
        en = 1'b0; we = 1'b0; addr = 8'd0; wdata = 32'd0;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        e;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_done;
        logic [15:0] exp_total;
    } vec_t;

    vec_t tv [8];

    initial begin
        tv[0] = '{1'b1, 1'b1, 8'h18, 32'h0000_00AB, 1'b0, 32'h0,         1'b0, 16'd1};
        tv[1] = '{1'b1, 1'b1, 8'h18, 32'h0000_003C, 1'b0, 32'h0,         1'b0, 16'd2};
        tv[2] = '{1'b1, 1'b0, 8'h18, 32'h0,         1'b1, 32'h3C00_0002, 1'b0, 16'd2};
        tv[3] = '{1'b1, 1'b1, 8'h04, 32'h0,         1'b0, 32'h0,         1'b1, 16'd2};
        tv[4] = '{1'b1, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0000_0006, 1'b1, 16'd2};
        tv[5] = '{1'b1, 1'b1, 8'h18, 32'h0000_0077, 1'b0, 32'h0,         1'b1, 16'd2};
        tv[6] = '{1'b1, 1'b0, 8'h1B, 32'h0,         1'b1, 32'h3C00_0002, 1'b1, 16'd2};
        tv[7] = '{1'b1, 1'b0, 8'h14, 32'h0,         1'b1, 32'h0,         1'b1, 16'd2};

        // Reset state while rst_n is held low
        model_reset();
        #12;
        check("reset rdata", rdata, 0);
        check("reset done", done, 0);
        check("reset cycle_count", cycle_count, 0);
        check("reset fail_total", fail_total, 0);

        // 1: watchdog expiry with an idle bus
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < MAXC - 1; k++) begin
            step(1'b0, 1'b0, 8'h00, 32'h0);
            check_all("wdog idle");
        end
        check("wdog done before limit", done, 0);
        check("wdog count at limit", cycle_count, 255);
        step(1'b0, 1'b0, 8'h00, 32'h0);
        check("wdog timed_out", timed_out, 1);
        check("wdog done", done, 1);
        check("wdog count frozen", cycle_count, 255);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00, 32'h0);
        check("wdog count still frozen", cycle_count, 255);
        step(1'b1, 1'b0, 8'h00, 32'h0);
        check("wdog STATUS", rdata, 32'h17);

        // 2: pass report then END
        do_reset();
        step(1'b1, 1'b1, 8'h10, 32'h0);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 8'h00, 32'h0);
        check("pass count before END", cycle_count, 10);
        step(1'b1, 1'b1, 8'h04, 32'h0);
        check("pass passed", passed, 1);
        check("pass fail_total", fail_total, 0);
        step(1'b1, 1'b0, 8'h00, 32'h0);
        check("pass STATUS", rdata, 32'h0D);
        check_all("pass");

        // 3: table of channel-2 failures, END, and ignored post-verdict writes
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(tv[i].e, tv[i].w, tv[i].a, tv[i].d);
            if (tv[i].chk_rd) check($sformatf("vec%0d rdata", i), rdata, tv[i].exp_rd);
            check($sformatf("vec%0d done", i), done, tv[i].exp_done);
            check($sformatf("vec%0d fail_total", i), fail_total, tv[i].exp_total);
        end
        check("vec passed low on FAIL", passed, 0);

        // 4: END exactly on the watchdog cycle
        do_reset();
        for (int k = 0; k < 300 && m_cycle < MAXC - 1; k++) step(1'b0, 1'b0, 8'h00, 32'h0);
        check("race count", cycle_count, 255);
        step(1'b1, 1'b1, 8'h04, 32'h0);
        check("race passed", passed, 1);
        check("race timed_out", timed_out, 0);
        step(1'b1, 1'b1, 8'h14, 32'h55);
        step(1'b1, 1'b0, 8'h14, 32'h0);
        check("race ch1 ignored", rdata, 0);
        check_all("race");

        // 5: saturation in the FAIL_W=2 instance
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'h14, 32'h80 + 32'(k));
        check("sat fail_total", s_fail_total, 3);
        check("wide fail_total", fail_total, 4);
        step(1'b1, 1'b0, 8'h14, 32'h0);
        check("sat ch1 read", s_rdata, 32'h8300_0003);
        check("wide ch1 read", rdata, 32'h8300_0004);

        // 6: asynchronous reset mid-run, then unmapped-read latency
        do_reset();
        step(1'b1, 1'b1, 8'h1C, 32'h05);
        step(1'b1, 1'b1, 8'h10, 32'h09);
        step(1'b1, 1'b0, 8'h08, 32'h0);
        for (int k = 0; k < 100 && m_cycle < 40; k++) step(1'b0, 1'b0, 8'h00, 32'h0);
        check_all("midrst before");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst cycle_count", cycle_count, 0);
        check("midrst fail_total", fail_total, 0);
        check("midrst rdata", rdata, 0);
        check("midrst done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 8'h00, 32'h0);
        check("midrst restart count", cycle_count, 1);
        step(1'b1, 1'b0, 8'h08, 32'h0);
        check("cycle read", rdata, 1);
        en = 1'b1; we = 1'b0; addr = 8'h40;
        #2;
        check("unmapped before edge", rdata, 1);
        @(posedge clk);
        #1;
        model_step(1'b1, 1'b0, 8'h40, 32'h0);
        en = 1'b0;
        check("unmapped read", rdata, 0);

        // Random traffic against the reference model
        for (int run = 0; run < 6; run++) begin
            int len = (run == 5) ? 300 : 80;
            do_reset();
            for (int k = 0; k < len; k++) begin
                int op = $urandom_range(0, 99);
                logic [7:0]  a;
                logic [31:0] d;
                if (op < 40) begin
                    a = 8'(8'h10 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3));
                    d = ($urandom_range(0, 9) < 3) ? 32'h0 : $urandom;
                    step(1'b1, 1'b1, a, d);
                end else if (op < 70) begin
                    a = 8'($urandom_range(0, 255));
                    step(1'b1, 1'b0, a, 32'h0);
                end else if (op < 75) begin
                    a = 8'($urandom_range(0, 255));
                    step(1'b1, 1'b1, a, $urandom);
                end else if (op < 77 && run != 5) begin
                    step(1'b1, 1'b1, 8'h04, $urandom);
                end else begin
                    step(1'b0, 1'b0, 8'($urandom), $urandom);
                end
                check_all($sformatf("rand r%0d k%0d", run, k));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
